// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned multiply / restoring divide engine that
// produces the HI/LO result pair. One iteration runs per clock. The pipeline
// stalls on busy, and done pulses for one cycle when a result is committed.
module muldiv_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] rs_value,
    input  logic [WIDTH-1:0] rt_value,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] low_out,
    output logic [WIDTH-1:0] high_out
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // Accumulator layout: upper WIDTH+1 bits hold the running partial product
    // or remainder. Lower WIDTH bits hold the multiplier or the dividend, and
    // are shifted out as the quotient bits shift in.
    localparam int ACC_W = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand (MUL) or divisor (DIV)
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_next;
    logic [ACC_W-1:0] div_shift;
    logic [WIDTH:0]   div_trial;
    logic [ACC_W-1:0] div_next;

    // Compute one shift-add step and one restoring-divide step from the current accumulator.
    always_comb begin
        mul_sum = acc_q[ACC_W-1:WIDTH];
        if (acc_q[0]) begin
            mul_sum = acc_q[ACC_W-1:WIDTH] + {1'b0, opnd_q};
        end
        mul_next = {mul_sum, acc_q[WIDTH-1:0]} >> 1;

        // The remainder is always below the divisor, so the shifted remainder
        // stays under 2*divisor. That fits in WIDTH+1 bits, and the top bit of
        // the trial difference is a valid sign.
        div_shift = {acc_q[ACC_W-2:0], 1'b0};
        div_trial = div_shift[ACC_W-1:WIDTH] - {1'b0, opnd_q};
        if (div_trial[WIDTH]) begin
            div_next = div_shift;
        end else begin
            div_next = {div_trial, div_shift[WIDTH-1:1], 1'b1};
        end
    end

    // Next-state logic: operation acceptance, iteration, commit of the HI/LO result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_d = '0;
                    if (!op) begin
                        state_d = S_MUL;
                        opnd_d  = rs_value;
                        acc_d   = {{(WIDTH + 1){1'b0}}, rt_value};
                    end else if (rt_value != '0) begin
                        state_d = S_DIV;
                        opnd_d  = rt_value;
                        acc_d   = {{(WIDTH + 1){1'b0}}, rs_value};
                    end else begin
                        // Divide by zero is resolved immediately without iterating.
                        state_d = S_DONE;
                        opnd_d  = rt_value;
                        acc_d   = {{(WIDTH + 1){1'b0}}, rs_value};
                        lo_d    = '1;
                        hi_d    = rs_value;
                        dbz_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    lo_d    = acc_d[WIDTH-1:0];
                    hi_d    = acc_d[2*WIDTH-1:WIDTH];
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign low_out     = lo_q;
    assign high_out    = hi_q;

endmodule
